// File: rtl/song_sequencer.sv
// Song sequencer: walks one song of an external synchronous note ROM and hands
// {note, duration} pairs to the note player using a new_note/note_done handshake.
module song_sequencer #(
  parameter int SONG_W     = 2,
  parameter int NOTE_IDX_W = 5,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         play,
  input  logic [SONG_W-1:0]            song,
  input  logic                         loop_en,
  input  logic                         next,
  input  logic                         note_done,
  output logic [SONG_W+NOTE_IDX_W-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]      rom_data,
  output logic [NOTE_W-1:0]            note,
  output logic [DUR_W-1:0]             duration,
  output logic                         new_note,
  output logic                         song_done,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, WAIT_DONE} state_t;

  state_t                state, state_next;
  logic [NOTE_IDX_W-1:0] note_idx, idx_next;
  logic [SONG_W-1:0]     song_latched, latched_next;
  logic                  load_note;
  logic                  done_pulse;
  logic                  end_of_song;
  logic [NOTE_W-1:0]     rom_note;
  logic [DUR_W-1:0]      rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];
  assign busy     = (state != IDLE);

  // A zero duration is the end-of-song marker and is never passed to the player;
  // running off the last ROM slot ends the song the same way.
  always_comb begin
    state_next   = state;
    idx_next     = note_idx;
    latched_next = song_latched;
    load_note    = 1'b0;
    done_pulse   = 1'b0;
    end_of_song  = 1'b0;
    case (state)
      IDLE: begin
        if (play) begin
          latched_next = song;
          idx_next     = '0;
          state_next   = FETCH;
        end
      end
      FETCH: begin
        if (play) state_next = LOAD;
      end
      LOAD: begin
        if (play) begin
          if (rom_dur != '0) begin
            load_note  = 1'b1;
            state_next = WAIT_DONE;
          end else begin
            end_of_song = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (play && (note_done || next)) begin
          if (&note_idx) begin
            end_of_song = 1'b1;
          end else begin
            idx_next   = note_idx + NOTE_IDX_W'(1);
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (end_of_song) begin
      if (loop_en) begin
        idx_next   = '0;
        state_next = FETCH;
      end else begin
        done_pulse = 1'b1;
        state_next = IDLE;
      end
    end
  end

  // The ROM address only moves on entry to FETCH, so a paused LOAD re-reads the same entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      note_idx     <= '0;
      song_latched <= '0;
      rom_addr     <= '0;
      note         <= '0;
      duration     <= '0;
      new_note     <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      state        <= state_next;
      note_idx     <= idx_next;
      song_latched <= latched_next;
      new_note     <= load_note;
      song_done    <= done_pulse;
      if (state_next == FETCH && state != FETCH) begin
        rom_addr <= {latched_next, idx_next};
      end
      if (load_note) begin
        note     <= rom_note;
        duration <= rom_dur;
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: behavioural note ROM, table-driven whole-song runs and
// hand-written sequences for loop, pause, skip and asynchronous reset.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic [1:0]  song;
  logic        loop_en;
  logic        next;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;
  logic        busy;

  song_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .play     (play),
    .song     (song),
    .loop_en  (loop_en),
    .next     (next),
    .note_done(note_done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note     (note),
    .duration (duration),
    .new_note (new_note),
    .song_done(song_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [128];

  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [5:0] note;
    logic [5:0] dur;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [1:0] song;
    int         exp_notes;
    int         exp_done_cyc;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   note_count = 0;
  int   done_count = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input int n, input int d, input int c);
    exp_t e;
    e.note = n[5:0];
    e.dur  = d[5:0];
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Reference walk of a song with note_done held high: one note every 3 cycles.
  task automatic push_song(input int s);
    logic [11:0] entry;
    for (int i = 0; i < 32; i++) begin
      entry = rom[s*32 + i];
      if (entry[5:0] == 6'd0) break;
      push_exp(int'(entry[11:6]), int'(entry[5:0]), 3*(i+1));
    end
  endtask

  // Scoreboard: every new_note pulse pops the next expected note.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (new_note === 1'b1) begin
        note_count++;
        if (sb.size() == 0) begin
          check_output("unexpected_new_note", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("note", int'(note), int'(e.note));
          check_output("duration", int'(duration), int'(e.dur));
          check_output("new_note_cycle", cyc, e.cyc);
        end
      end
      if (song_done === 1'b1) done_count++;
    end
  end

  task automatic apply_stimulus(input vec_t v);
    int done_at;
    note_count = 0;
    done_count = 0;
    done_at    = -1;
    push_song(int'(v.song));
    song      = v.song;
    loop_en   = 1'b0;
    next      = 1'b0;
    note_done = 1'b1;
    play      = 1'b1;
    cyc       = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (song_done) begin
        done_at = cyc;
        play    = 1'b0;
        break;
      end
    end
    check_output("song_done_cycle", done_at, v.exp_done_cyc);
    tick();
    check_output("busy_after_done", int'(busy), 0);
    check_output("note_count", note_count, v.exp_notes);
    check_output("done_count", done_count, 1);
    check_output("queue_empty", sb.size(), 0);
  endtask

  vec_t vecs[4];

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    for (int i = 0; i < 4; i++) rom[i] = {6'(i+1), 6'd8};
    for (int i = 0; i < 32; i++) rom[32+i] = {6'(i+10), 6'(i+1)};
    rom[64] = {6'd20, 6'd5};
    rom[65] = {6'd0, 6'd3};
    rom[96] = {6'd33, 6'd0};

    vecs[0] = '{song: 2'd0, exp_notes: 4,  exp_done_cyc: 15};
    vecs[1] = '{song: 2'd1, exp_notes: 32, exp_done_cyc: 97};
    vecs[2] = '{song: 2'd2, exp_notes: 2,  exp_done_cyc: 9};
    vecs[3] = '{song: 2'd3, exp_notes: 0,  exp_done_cyc: 3};

    reset_n = 1'b0; play = 1'b0; song = 2'd0; loop_en = 1'b0; next = 1'b0; note_done = 1'b0;
    #3;
    check_output("reset_rom_addr", int'(rom_addr), 0);
    check_output("reset_note", int'(note), 0);
    check_output("reset_duration", int'(duration), 0);
    check_output("reset_new_note", int'(new_note), 0);
    check_output("reset_song_done", int'(song_done), 0);
    check_output("reset_busy", int'(busy), 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Loop mode: the marker restarts song 0 with no song_done.
    done_count = 0;
    push_song(0);
    push_exp(1, 8, 17);
    song = 2'd0; loop_en = 1'b1; note_done = 1'b1; next = 1'b0; play = 1'b1;
    cyc = 0;
    while (cyc < 15) tick();
    check_output("loop_rom_addr_wrap", int'(rom_addr), 0);
    while (cyc < 17) tick();
    play = 1'b0;
    tick();
    check_output("loop_no_song_done", done_count, 0);
    check_output("loop_queue_empty", sb.size(), 0);
    check_output("loop_busy_paused", int'(busy), 1);

    // Asynchronous reset in the middle of a (paused) WAIT_DONE.
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_note", int'(note), 0);
    check_output("async_rst_duration", int'(duration), 0);
    check_output("async_rst_rom_addr", int'(rom_addr), 0);
    check_output("async_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    loop_en = 1'b0; note_done = 1'b1; song = 2'd2; play = 1'b1;
    done_count = 0;
    push_song(2);
    cyc = 0;
    reset_n = 1'b1;
    while (cyc < 3) tick();
    check_output("post_reset_rom_addr", int'(rom_addr), 64);
    check_output("post_reset_new_note", int'(new_note), 1);
    while (cyc < 9) tick();
    check_output("song2_done_pulse", int'(song_done), 1);
    play = 1'b0;
    tick();
    check_output("song2_done_count", done_count, 1);

    // Pause with note_done held, then combined next+note_done, then next alone.
    note_count = 0;
    push_exp(10, 1, 3);
    push_exp(11, 2, 16);
    push_exp(12, 3, 21);
    push_exp(13, 4, 27);
    song = 2'd1; note_done = 1'b1; next = 1'b0; play = 1'b1;
    cyc = 0;
    while (cyc < 3) tick();
    play = 1'b0;
    while (cyc < 13) tick();
    check_output("pause_note_count", note_count, 1);
    check_output("pause_note_held", int'(note), 10);
    check_output("pause_busy", int'(busy), 1);
    play = 1'b1;
    while (cyc < 16) tick();
    note_done = 1'b0;
    while (cyc < 18) tick();
    note_done = 1'b1;
    next = 1'b1;
    tick();
    note_done = 1'b0;
    next = 1'b0;
    while (cyc < 21) tick();
    check_output("single_advance_addr", int'(rom_addr), 34);
    while (cyc < 24) tick();
    check_output("no_extra_note", note_count, 3);
    next = 1'b1;
    tick();
    next = 1'b0;
    while (cyc < 27) tick();
    check_output("skip_addr", int'(rom_addr), 35);
    play = 1'b0;
    tick();
    tick();
    check_output("skip_note_count", note_count, 4);
    check_output("final_queue_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
